// File: rtl/systolic_pkg.sv
// Shared definitions for the 4x4 weight-stationary systolic array controller.
// Contents: array dimension N, skew depth SKEW_MAX, element/vector types,
// and the sequencer state encoding.
package systolic_pkg;

    localparam int unsigned N        = 4;
    localparam int unsigned SKEW_MAX = N - 1;
    localparam int unsigned DATA_W   = 16;

    typedef logic signed [DATA_W-1:0] elem_t;
    typedef elem_t [N-1:0]            vec_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/delay_line.sv
// Fixed-length shift register; DEPTH=0 degenerates to a plain wire.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset, clears every stage
//   d_i    - data in (WIDTH bits)
//   q_o    - data out, d_i delayed DEPTH cycles
module delay_line
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign q_o = d_i;
    end else begin : g_reg
        logic [DEPTH-1:0][WIDTH-1:0] sr_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sr_q <= '0;
            end else begin
                sr_q[0] <= d_i;
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    sr_q[k] <= sr_q[k-1];
                end
            end
        end

        assign q_o = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Controller for the 4x4 weight-stationary systolic array: holds weights,
// accepts activation vectors (valid/ready), skews them into the array,
// de-skews the row outputs and returns aligned result vectors.
// Ports:
//   clk, rst (async active-low)        clocking / reset
//   start, len, busy, done             job control
//   w_we, w_row, w_col, w_data         weight write (IDLE only)
//   a_valid, a_ready, a_data           activation stream in
//   r_valid, r_data                    result stream out (no backpressure)
//   arr_weights, arr_in_left, arr_in_up, arr_out_right   array interface
// Optional: define SEQ_PERF_CNT_EN to add perf_busy / perf_bubble counters.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ARRAY_LAT = 4,
    parameter int unsigned MAX_LEN   = 256,
    parameter int unsigned LW        = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LW-1:0]        len,
    output logic                 busy,
    output logic                 done,
    input  logic                 w_we,
    input  logic [1:0]           w_row,
    input  logic [1:0]           w_col,
    input  logic [WIDTH-1:0]     w_data,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [N*WIDTH-1:0]   a_data,
    output logic                 r_valid,
    output logic [N*WIDTH-1:0]   r_data,
    output logic [N*N*WIDTH-1:0] arr_weights,
    output logic [N*WIDTH-1:0]   arr_in_left,
    output logic [N*WIDTH-1:0]   arr_in_up,
    input  logic [N*WIDTH-1:0]   arr_out_right
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]          perf_busy,
    output logic [31:0]          perf_bubble
`endif
);

    localparam int unsigned TAG_LEN = ARRAY_LAT + 4;
    localparam int unsigned DW      = $clog2(TAG_LEN + 1);

    seq_state_e                state_q, state_d;
    logic [LW-1:0]             len_q, acc_cnt_q, len_sat;
    logic [DW-1:0]             drain_cnt_q;
    logic [N*N-1:0][WIDTH-1:0] w_q;
    logic                      accept, start_go, tag_out, r_valid_q;
    logic [N*WIDTH-1:0]        aligned, r_data_q;

    assign accept   = a_valid && a_ready;
    assign start_go = (state_q == S_IDLE) && start;
    assign len_sat  = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = (len_sat == '0) ? S_DRAIN : S_STREAM;
            S_STREAM: if (accept && (acc_cnt_q == len_q - LW'(1))) state_d = S_DRAIN;
            // One spare cycle beyond the pipeline depth so done never precedes the last r_valid.
            S_DRAIN:  if (drain_cnt_q == DW'(TAG_LEN)) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        a_ready = (state_q == S_STREAM) && (acc_cnt_q < len_q);
    end

    // ---------------- job counters ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q       <= '0;
            acc_cnt_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            if (start_go) begin
                len_q     <= len_sat;
                acc_cnt_q <= '0;
            end else if (accept) begin
                acc_cnt_q <= acc_cnt_q + LW'(1);
            end
            if (state_q == S_DRAIN) drain_cnt_q <= drain_cnt_q + DW'(1);
            else                    drain_cnt_q <= '0;
        end
    end

    // ---------------- weight registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q <= '0;
        end else if (w_we && (state_q == S_IDLE)) begin
            w_q[{w_row, w_col}] <= w_data;
        end
    end

    assign arr_weights = w_q;
    assign arr_in_up   = '0;

    // ---------------- skew / deskew lanes ----------------
    // Lane i is delayed i+1 going in and SKEW_MAX-i coming out, so every lane
    // sees the same total delay and the result row reassembles aligned.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [WIDTH-1:0] skew_in;
        assign skew_in = accept ? a_data[i*WIDTH +: WIDTH] : '0;

        delay_line #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_skew (
            .clk_i  (clk),
            .rst_ni (rst),
            .d_i    (skew_in),
            .q_o    (arr_in_left[i*WIDTH +: WIDTH])
        );

        delay_line #(.WIDTH(WIDTH), .DEPTH(SKEW_MAX - i)) u_deskew (
            .clk_i  (clk),
            .rst_ni (rst),
            .d_i    (arr_out_right[i*WIDTH +: WIDTH]),
            .q_o    (aligned[i*WIDTH +: WIDTH])
        );
    end

    // Valid tag follows the data path so bubbles keep their position.
    delay_line #(.WIDTH(1), .DEPTH(TAG_LEN)) u_tag (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (accept),
        .q_o    (tag_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= tag_out;
            r_data_q  <= aligned;
        end
    end

    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_busy_q, perf_bubble_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_busy_q   <= '0;
            perf_bubble_q <= '0;
        end else if (start_go) begin
            perf_busy_q   <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (busy && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
            if ((state_q == S_STREAM) && a_ready && !a_valid && (perf_bubble_q != '1))
                perf_bubble_q <= perf_bubble_q + 32'd1;
        end
    end

    assign perf_busy   = perf_busy_q;
    assign perf_bubble = perf_bubble_q;
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer with a pure-delay array stub.
module tb_systolic_sequencer;
    import systolic_pkg::*;

    localparam int unsigned W   = 16;
    localparam int unsigned LAT = 4;
    localparam int unsigned LW  = 9;

    logic               clk, rst, start, busy, done, w_we, a_valid, a_ready, r_valid;
    logic [LW-1:0]      len;
    logic [1:0]         w_row, w_col;
    logic [W-1:0]       w_data;
    logic [N*W-1:0]     a_data, r_data, arr_in_left, arr_in_up, arr_out_right;
    logic [N*N*W-1:0]   arr_weights;

    int total = 0;
    int bad   = 0;
    int nrv, dn, bc, rdy, acc;

    systolic_sequencer #(.WIDTH(W), .ARRAY_LAT(LAT), .MAX_LEN(256)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
        .w_we(w_we), .w_row(w_row), .w_col(w_col), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .r_valid(r_valid), .r_data(r_data), .arr_weights(arr_weights),
        .arr_in_left(arr_in_left), .arr_in_up(arr_in_up), .arr_out_right(arr_out_right)
    );

    // Array stub: pure delay of LAT cycles.
    logic [N*W-1:0] stub_q [LAT];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) stub_q[i] <= '0;
        end else begin
            stub_q[0] <= arr_in_left;
            for (int i = 1; i < LAT; i++) stub_q[i] <= stub_q[i-1];
        end
    end
    assign arr_out_right = stub_q[LAT-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t vec4(input int a, input int b, input int c, input int d);
        vec_t v;
        v[0] = 16'(a); v[1] = 16'(b); v[2] = 16'(c); v[3] = 16'(d);
        return v;
    endfunction

    function automatic logic [W-1:0] wt(input int r, input int c);
        return arr_weights[(r*4+c)*W +: W];
    endfunction

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; len = '0; w_we = 1'b0; w_row = '0; w_col = '0;
        w_data = '0; a_valid = 1'b0; a_data = '0;
        step(); step();

        // ---- reset state ----
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkb("rst_ready", a_ready, 1'b0);
        chkb("rst_rvalid", r_valid, 1'b0);
        chkv("rst_rdata", 256'(r_data), '0);
        chkv("rst_left", 256'(arr_in_left), '0);
        chkv("rst_up", 256'(arr_in_up), '0);
        chkv("rst_weights", arr_weights, '0);
        rst = 1'b1;
        step();

        // ---- 1: weight write in IDLE ----
        w_we = 1'b1; w_row = 2'd2; w_col = 2'd1; w_data = 16'd7;
        step();
        w_we = 1'b0;
        chkv("t1_w21", 256'(wt(2, 1)), 256'(16'd7));

        // ---- 2: single vector, plus write attempt while busy ----
        start = 1'b1; len = 9'd1;
        step();
        start = 1'b0;
        chkb("t2_busy", busy, 1'b1);
        chkb("t2_ready", a_ready, 1'b1);
        w_we = 1'b1; w_row = 2'd2; w_col = 2'd1; w_data = 16'd9;
        a_valid = 1'b1; a_data = vec4(1, 2, 3, 4);
        step();
        w_we = 1'b0; a_valid = 1'b0; a_data = '0;
        chkv("t1_busy_write_ignored", 256'(wt(2, 1)), 256'(16'd7));
        chkb("t2_ready_low", a_ready, 1'b0);
        chkv("t2_skew_lane0", 256'(arr_in_left[15:0]), 256'(16'd1));
        nrv = 0; dn = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 3) chkv("t2_skew_lane3", 256'(arr_in_left[63:48]), 256'(16'd4));
            if (k == 8) begin
                chkb("t2_rvalid", r_valid, 1'b1);
                chkv("t2_rdata", 256'(r_data), 256'(vec4(1, 2, 3, 4)));
            end else begin
                nrv += int'(r_valid);
            end
            if (k == 9) chkb("t2_done", done, 1'b1);
            else        dn += int'(done);
        end
        chki("t2_stray_rvalid", nrv, 0);
        chki("t2_early_done", dn, 0);
        step();
        chkb("t2_idle", busy, 1'b0);

        // ---- 3: four back-to-back vectors, start pulsed while busy ----
        start = 1'b1; len = 9'd4;
        step();
        start = 1'b0;
        a_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            a_data = vec4(j, j + 1, j + 2, j + 3);
            step();
            chkb("t3_ready", a_ready, (j < 3));
        end
        a_valid = 1'b0; a_data = '0;
        nrv = 0; dn = 0;
        for (int k = 4; k <= 12; k++) begin
            if (k == 6) begin start = 1'b1; len = 9'd2; end
            step();
            start = 1'b0;
            if (k >= 8 && k <= 11) begin
                chkb("t3_rvalid", r_valid, 1'b1);
                chkv("t3_rdata", 256'(r_data), 256'(vec4(k - 8, k - 7, k - 6, k - 5)));
            end else begin
                nrv += int'(r_valid);
            end
            if (k == 12) chkb("t3_done", done, 1'b1);
            else         dn += int'(done);
        end
        chki("t3_stray_rvalid", nrv, 0);
        chki("t3_early_done", dn, 0);
        step();
        chkb("t3_idle", busy, 1'b0);
        step();
        chkb("t3_start_ignored", busy, 1'b0);

        // ---- 4: three vectors with a bubble between each ----
        start = 1'b1; len = 9'd3;
        step();
        start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            a_valid = ((j % 2) == 0);
            a_data  = vec4(5 + 4*(j/2), 6 + 4*(j/2), 7 + 4*(j/2), 8 + 4*(j/2));
            step();
            if (j == 1) chkb("t4_ready_in_gap", a_ready, 1'b1);
        end
        a_valid = 1'b0; a_data = '0;
        chkb("t4_ready_end", a_ready, 1'b0);
        nrv = 0; dn = 0;
        for (int k = 5; k <= 13; k++) begin
            step();
            if (k == 8 || k == 10 || k == 12) begin
                chkb("t4_rvalid", r_valid, 1'b1);
                chkv("t4_rdata", 256'(r_data),
                     256'(vec4(5 + 2*(k-8), 6 + 2*(k-8), 7 + 2*(k-8), 8 + 2*(k-8))));
            end else begin
                nrv += int'(r_valid);
            end
            if (k == 13) chkb("t4_done", done, 1'b1);
            else         dn += int'(done);
        end
        chki("t4_gap_rvalid", nrv, 0);
        chki("t4_early_done", dn, 0);
        step();

        // ---- 5: empty job ----
        start = 1'b1; len = 9'd0;
        step();
        start = 1'b0;
        bc = 0; dn = 0; nrv = 0; rdy = 0;
        for (int i = 0; i < 30 && busy; i++) begin
            bc++;
            dn  += int'(done);
            nrv += int'(r_valid);
            rdy += int'(a_ready);
            step();
        end
        chkb("t5_finished", busy, 1'b0);
        chki("t5_busy_cycles", bc, 2 + LAT + 4);
        chki("t5_done_pulses", dn, 1);
        chki("t5_rvalid", nrv, 0);
        chki("t5_ready", rdy, 0);

        // ---- 7: oversize len saturates at MAX_LEN ----
        start = 1'b1; len = 9'd300;
        step();
        start = 1'b0;
        acc = 0; nrv = 0; dn = 0;
        a_valid = 1'b1;
        for (int i = 0; i < 280; i++) begin
            a_data = vec4(i, i, i, i);
            if (a_ready) acc++;
            step();
            nrv += int'(r_valid);
            dn  += int'(done);
        end
        a_valid = 1'b0; a_data = '0;
        chki("t7_accepted", acc, 256);
        chki("t7_results", nrv, 256);
        chki("t7_done", dn, 1);
        chkb("t7_idle", busy, 1'b0);

        // ---- 6: reset mid-STREAM ----
        start = 1'b1; len = 9'd4;
        step();
        start = 1'b0;
        a_valid = 1'b1; a_data = vec4(21, 22, 23, 24);
        step();
        step();
        rst = 1'b0;
        #1;
        a_valid = 1'b0; a_data = '0;
        chkb("t6_busy", busy, 1'b0);
        chkb("t6_ready", a_ready, 1'b0);
        chkb("t6_done", done, 1'b0);
        chkb("t6_rvalid", r_valid, 1'b0);
        chkv("t6_left", 256'(arr_in_left), '0);
        chkv("t6_rdata", 256'(r_data), '0);
        chkv("t6_weights", arr_weights, '0);
        step(); step();
        rst = 1'b1;
        nrv = 0; dn = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            nrv += int'(r_valid);
            dn  += int'(done);
        end
        chki("t6_no_rvalid_after", nrv, 0);
        chki("t6_no_done_after", dn, 0);

        // new job; weight write in the same cycle as start
        w_we = 1'b1; w_row = 2'd0; w_col = 2'd3; w_data = 16'hFFFB;
        start = 1'b1; len = 9'd1;
        step();
        w_we = 1'b0; start = 1'b0;
        chkv("t6_w03_with_start", 256'(wt(0, 3)), 256'(16'hFFFB));
        chkb("t6_busy_new", busy, 1'b1);
        a_valid = 1'b1; a_data = vec4(-3, 5, -7, 9);
        step();
        a_valid = 1'b0; a_data = '0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 8) begin
                chkb("t6_rvalid_new", r_valid, 1'b1);
                chkv("t6_rdata_new", 256'(r_data), 256'(vec4(-3, 5, -7, 9)));
            end
            if (k == 9) chkb("t6_done_new", done, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
